param_switch_core: RTL

//  Parametrised NxN packet switch core; successor of the fixed 4-port switch DUT.

---
 rtl/switch_pkg.sv | 23 ++
 rtl/switch_out_fifo.sv | 41 ++++
 rtl/param_switch_core.sv | 92 +++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared packet type and round-robin pick for the parametrised switch.
package switch_pkg;
    localparam int PKT_DW = 8;
    localparam int PKT_AW = 8;
    localparam int MAXP = 8;

    typedef struct packed {
        logic [PKT_AW-1:0] addr;
        logic [PKT_DW-1:0] data;
    } pkt_t;

    // One-hot grant to the first requester at or after ptr, wrapping over n ports.
    function automatic logic [MAXP-1:0] rr_pick(input logic [MAXP-1:0] req, input int ptr, input int n);
        logic [MAXP-1:0] g;
        int idx;
        g = '0;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (req[idx]) g = MAXP'(1) << idx;
        end
        return g;
    endfunction
endpackage

// File: rtl/switch_out_fifo.sv
// switch_out_fifo: synchronous first-word-fall-through FIFO; head reads as 0 when empty.
module switch_out_fifo import switch_pkg::*; #(
    parameter int DEPTH = 4,
    parameter type T = pkt_t
) (
    input  logic clk,
    input  logic reset,
    input  logic wr,
    input  T     wdata,
    input  logic rd,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic push, pop;

    assign full = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign push = wr & ~full;
    assign pop = rd & ~empty;
    assign rdata = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/param_switch_core.sv
// param_switch_core: NxN packet switch with per-input holding regs, per-output
// round-robin arbitration into FWFT FIFOs, and a saturating drop counter.
module param_switch_core import switch_pkg::*; #(
    parameter int NPORTS = 4,
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int DEPTH = 4,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS*DW-1:0] data_in,
    input  logic [NPORTS*AW-1:0] addr_in,
    input  logic [NPORTS-1:0]    valid_in,
    output logic [NPORTS-1:0]    rcv_rdy,
    output logic [NPORTS*DW-1:0] data_out,
    output logic [NPORTS*AW-1:0] addr_out,
    output logic [NPORTS-1:0]    valid_out,
    input  logic [NPORTS-1:0]    data_rd,
    output logic [CNTW-1:0]      drop_cnt
);
    localparam int DESTW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pkt_loc_t;

    pkt_loc_t hold [NPORTS];
    logic [NPORTS-1:0] hold_v, drop, grant, full, empty, wr;
    logic [NPORTS-1:0][NPORTS-1:0] gnt;
    logic [DESTW-1:0] dest [NPORTS];
    logic [DESTW-1:0] rr_ptr [NPORTS];
    logic [CNTW+3:0] cnt_sum;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NPORTS; i++) begin
            dest[i] = hold[i].addr[DESTW-1:0];
            drop[i] = hold_v[i] & (int'(dest[i]) >= NPORTS);
            for (int j = 0; j < NPORTS; j++) grant[i] = grant[i] | gnt[j][i];
        end
    end

    assign rcv_rdy = ~hold_v | grant;
    assign cnt_sum = (CNTW+4)'(drop_cnt) + (CNTW+4)'($countones(drop));

    for (genvar j = 0; j < NPORTS; j++) begin : g_out
        logic [MAXP-1:0] req, pick;
        pkt_loc_t wdata, head;
        always_comb begin
            req = '0;
            wdata = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req[i] = hold_v[i] & ~drop[i] & (int'(dest[i]) == j);
                if (gnt[j][i]) wdata = hold[i];
            end
        end
        assign pick = rr_pick(req, int'(rr_ptr[j]), NPORTS);
        // Full is the registered flag, so a pop this cycle does not free a slot until next cycle.
        assign gnt[j] = full[j] ? '0 : pick[NPORTS-1:0];
        assign wr[j] = ~full[j] & (|pick);
        switch_out_fifo #(.DEPTH(DEPTH), .T(pkt_loc_t)) u_fifo (
            .clk(clk), .reset(reset), .wr(wr[j]), .wdata(wdata), .rd(data_rd[j]),
            .rdata(head), .full(full[j]), .empty(empty[j])
        );
        assign data_out[j*DW +: DW] = head.data;
        assign addr_out[j*AW +: AW] = head.addr;
        assign valid_out[j] = ~empty[j];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v <= '0;
            drop_cnt <= '0;
            for (int j = 0; j < NPORTS; j++) rr_ptr[j] <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (valid_in[i] & rcv_rdy[i]) begin
                    hold_v[i] <= 1'b1;
                    hold[i] <= {addr_in[i*AW +: AW], data_in[i*DW +: DW]};
                end else if (grant[i] | drop[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
            for (int j = 0; j < NPORTS; j++)
                for (int i = 0; i < NPORTS; i++)
                    if (gnt[j][i]) rr_ptr[j] <= DESTW'((i + 1) % NPORTS);
            drop_cnt <= (|cnt_sum[CNTW+3:CNTW]) ? '1 : cnt_sum[CNTW-1:0];
        end
    end
endmodule
